// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of arbitrary depth with occupancy counter,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a registered read port with a data-valid strobe.
// Full/empty come from a dedicated count register, never from pointer
// comparison, so any depth (not only powers of two) works unchanged.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 16,
    parameter int AF_THRESH  = LENGTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int CNT_W     = $clog2(LENGTH + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_flush,
    input  logic                  i_clear_err,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_read,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int PTR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(LENGTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO_C = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(1);

    // Pointer advance with explicit wrap at LENGTH-1 (depth need not be 2^n).
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST_C) begin
            n = PTR_ZERO_C;
        end else begin
            n = p + PTR_ONE_C;
        end
        return n;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [LENGTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  aempty_q, aempty_d;
    logic                  afull_q, afull_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  rd_do_s;
    logic                  wr_do_s;
    logic                  ovf_set_s;
    logic                  udf_set_s;

    // Acceptance against the pre-edge count; a flush cycle suppresses all effects.
    always_comb begin
        rd_acc_s  = i_read & (count_q != ZERO_C);
        wr_acc_s  = i_write & ((count_q != LEN_C) | rd_acc_s);
        rd_do_s   = rd_acc_s & ~i_flush;
        wr_do_s   = wr_acc_s & ~i_flush;
        ovf_set_s = i_write & ~wr_acc_s & ~i_flush;
        udf_set_s = i_read & ~rd_acc_s & ~i_flush;
    end

    // Next-state for pointers, count, read port, error flags and status flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = 1'b0;

        if (i_flush) begin
            wr_ptr_d = PTR_ZERO_C;
            rd_ptr_d = PTR_ZERO_C;
            count_d  = ZERO_C;
            valid_d  = 1'b0;
        end else begin
            if (wr_do_s) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_do_s) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
                data_d   = mem_q[rd_ptr_q];
                valid_d  = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
                data_d   = data_q;
                valid_d  = 1'b0;
            end
            case ({wr_do_s, rd_do_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end

        // A new error in the same cycle as a clear request still sets the flag.
        if (i_clear_err) begin
            ovf_d = ovf_set_s;
            udf_d = udf_set_s;
        end else begin
            ovf_d = ovf_q | ovf_set_s;
            udf_d = udf_q | udf_set_s;
        end

        empty_d  = (count_d == ZERO_C);
        full_d   = (count_d == LEN_C);
        aempty_d = (count_d <= AE_C);
        afull_d  = (count_d >= AF_C);
    end

    // Storage write; contents are intentionally not cleared by reset or flush.
    always_ff @(posedge i_clock) begin
        if (wr_do_s) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            wr_ptr_q <= PTR_ZERO_C;
            rd_ptr_q <= PTR_ZERO_C;
            count_q  <= ZERO_C;
            data_q   <= {DATA_WIDTH{1'b0}};
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign o_data         = data_q;
    assign o_valid        = valid_q;
    assign o_empty        = empty_q;
    assign o_full         = full_q;
    assign o_almost_empty = aempty_q;
    assign o_almost_full  = afull_q;
    assign o_count        = count_q;
    assign o_overflow     = ovf_q;
    assign o_underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo. Instance 0 is LENGTH=5
// (non-power-of-two wrap), instance 1 is LENGTH=16 with AF=14, AE=2.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic [1:0] rstn  = 2'b00;
    logic [1:0] flush = 2'b00;
    logic [1:0] clr   = 2'b00;
    logic [1:0] wr    = 2'b00;
    logic [1:0] rd    = 2'b00;
    logic [7:0] din0  = 8'h00;
    logic [7:0] din1  = 8'h00;
    logic [7:0] dout0, dout1;
    logic [1:0] valid, empty, full, aemp, afull, ovf, udf;
    logic [2:0] cnt0;
    logic [4:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;
    int n_popped = 0;

    // Bench-side expectations
    int         m_cnt  [2];
    logic       m_ovf  [2];
    logic       m_udf  [2];
    logic [7:0] m_last [2];
    logic [7:0] q5  [$];
    logic [7:0] q16 [$];
    int         m_len  [2] = '{5, 16};
    int         m_af   [2] = '{3, 14};

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(8), .LENGTH(5)) u_fifo5 (
        .i_clock(clk), .i_reset_n(rstn[0]), .i_flush(flush[0]), .i_clear_err(clr[0]),
        .i_write(wr[0]), .i_data(din0), .i_read(rd[0]),
        .o_data(dout0), .o_valid(valid[0]), .o_empty(empty[0]), .o_full(full[0]),
        .o_almost_empty(aemp[0]), .o_almost_full(afull[0]), .o_count(cnt0),
        .o_overflow(ovf[0]), .o_underflow(udf[0])
    );

    sync_fifo #(.DATA_WIDTH(8), .LENGTH(16), .AF_THRESH(14), .AE_THRESH(2)) u_fifo16 (
        .i_clock(clk), .i_reset_n(rstn[1]), .i_flush(flush[1]), .i_clear_err(clr[1]),
        .i_write(wr[1]), .i_data(din1), .i_read(rd[1]),
        .o_data(dout1), .o_valid(valid[1]), .o_empty(empty[1]), .o_full(full[1]),
        .o_almost_empty(aemp[1]), .o_almost_full(afull[1]), .o_count(cnt1),
        .o_overflow(ovf[1]), .o_underflow(udf[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input int s, input logic exp_valid);
        logic [7:0] d;
        int         c;
        d = (s == 0) ? dout0 : dout1;
        c = (s == 0) ? int'(cnt0) : int'(cnt1);
        check($sformatf("valid%0d", s), {31'd0, valid[s]}, {31'd0, exp_valid});
        check($sformatf("data%0d", s), {24'd0, d}, {24'd0, m_last[s]});
        check($sformatf("count%0d", s), c, m_cnt[s]);
        check($sformatf("empty%0d", s), {31'd0, empty[s]}, (m_cnt[s] == 0) ? 32'd1 : 32'd0);
        check($sformatf("full%0d", s), {31'd0, full[s]}, (m_cnt[s] == m_len[s]) ? 32'd1 : 32'd0);
        check($sformatf("aempty%0d", s), {31'd0, aemp[s]}, (m_cnt[s] <= 2) ? 32'd1 : 32'd0);
        check($sformatf("afull%0d", s), {31'd0, afull[s]}, (m_cnt[s] >= m_af[s]) ? 32'd1 : 32'd0);
        check($sformatf("ovf%0d", s), {31'd0, ovf[s]}, {31'd0, m_ovf[s]});
        check($sformatf("udf%0d", s), {31'd0, udf[s]}, {31'd0, m_udf[s]});
    endtask

    // One clock cycle of stimulus on instance s, with expected results queued.
    task automatic step(input int s, input logic w, input logic [7:0] d, input logic r,
                        input logic fl, input logic ce);
        logic       ra, wa;
        logic [7:0] popped;
        ra = 1'b0;
        wa = 1'b0;
        popped = m_last[s];
        wr[s] = w; rd[s] = r; flush[s] = fl; clr[s] = ce;
        if (s == 0) din0 = d; else din1 = d;
        if (fl) begin
            m_cnt[s] = 0;
            if (s == 0) q5.delete(); else q16.delete();
            if (ce) begin
                m_ovf[s] = 1'b0;
                m_udf[s] = 1'b0;
            end
        end else begin
            ra = r && (m_cnt[s] > 0);
            wa = w && ((m_cnt[s] < m_len[s]) || ra);
            if (ra) begin
                if (s == 0) popped = q5.pop_front(); else popped = q16.pop_front();
                m_cnt[s]--;
            end
            if (wa) begin
                if (s == 0) q5.push_back(d); else q16.push_back(d);
                m_cnt[s]++;
            end
            m_ovf[s] = (w && !wa) || (m_ovf[s] && !ce);
            m_udf[s] = (r && !ra) || (m_udf[s] && !ce);
        end
        @(posedge clk);
        #1;
        wr[s] = 1'b0; rd[s] = 1'b0; flush[s] = 1'b0; clr[s] = 1'b0;
        if (ra) n_popped++;
        m_last[s] = popped;
        check_outputs(s, ra);
    endtask

    // Hold reset for one edge (optionally with a write pending) and check reset values.
    task automatic do_reset(input int s, input logic w);
        rstn[s] = 1'b0;
        wr[s] = w;
        rd[s] = w;
        @(posedge clk);
        #1;
        rstn[s] = 1'b1;
        wr[s] = 1'b0;
        rd[s] = 1'b0;
        m_cnt[s] = 0; m_ovf[s] = 1'b0; m_udf[s] = 1'b0; m_last[s] = 8'h00;
        if (s == 0) q5.delete(); else q16.delete();
        check_outputs(s, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0; m_last[k] = 8'h00;
        end
        #1;
        do_reset(0, 1'b0);
        do_reset(1, 1'b0);

        // Fill LENGTH=5, then overflow
        for (int i = 1; i <= 5; i++) step(0, 1'b1, 8'(8'h11 * i), 1'b0, 1'b0, 1'b0);
        check("full_after_5", {31'd0, full[0]}, 32'd1);
        step(0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        check("ovf_on_6th", {31'd0, ovf[0]}, 32'd1);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("udf_extra_read", {31'd0, udf[0]}, 32'd1);
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Drain with wrap
        for (int i = 0; i < 3; i++) step(0, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("empty_after_drain", {31'd0, empty[0]}, 32'd1);
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Simultaneous access: full, then empty
        for (int i = 1; i <= 5; i++) step(0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check("full_rw_head", {24'd0, dout0}, 32'h01);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("tail_is_77", {24'd0, dout0}, 32'h77);
        step(0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        check("empty_rw_udf", {31'd0, udf[0]}, 32'd1);
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush with overflow set and count = 4, then clear errors
        for (int i = 0; i < 6; i++) step(0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check("flush_keeps_ovf", {31'd0, ovf[0]}, 32'd1);
        step(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clear_ovf", {31'd0, ovf[0]}, 32'd0);
        step(0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Thresholds on LENGTH=16: fill up, then drain back
        for (int i = 0; i < 16; i++) step(1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random streaming, then reset while count = 7
        for (int i = 0; i < 150; i++)
            step(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (m_cnt[1] < 7) step(1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            else if (m_cnt[1] > 7) step(1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        check("count_before_reset", {27'd0, cnt1}, 32'd7);
        do_reset(1, 1'b1);
        n_popped = 0;
        for (int i = 0; i < 2000 && n_popped < 200; i++)
            step(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("popped_200", (n_popped >= 200) ? 32'd1 : 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
